// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// The checksum state exists only when LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CHK_W      = 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_FIN    = 3'd6
    } loader_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FIN    = 3'd6
    } loader_state_t;
`endif

    // Byte address of word idx; wraps modulo 2^64.
    function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [15:0] idx);
        return base + {46'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs four little-endian stream bytes into one 32-bit word.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;

    // word/word_full describe the word completed by the byte accepted this cycle
    assign word      = {byte_in, sh_q[31:8]};
    assign word_full = byte_en && (cnt_q == 2'(WORD_BYTES - 1));

    // Next-state for the byte counter and shift register
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (clr) begin
            cnt_d = 2'd0;
            sh_d  = 32'd0;
        end else if (byte_en) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = {byte_in, sh_q[31:8]};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and shift register flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sh_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams header/payload bytes into Memoria32 while holding the CPU in reset.
// Optional trailing checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD_START,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic [63:0] MEM_WADDR,
    output logic [31:0] MEM_DATAIN,
    output logic        MEM_WR,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    loader_state_t state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   idx_q, idx_d;
    logic [63:0]   waddr_q, waddr_d;
    logic [31:0]   datain_q, datain_d;
    logic          wr_q, wr_d;
    logic          ready_q, ready_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept_s;
    logic          pk_clr_s;
    logic          pk_full_s;
    logic [31:0]   pk_word_s;
    logic [15:0]   hdr_n_s;
`ifdef LOADER_CHECKSUM_EN
    logic [CHK_W-1:0] chk_q, chk_d;
`endif

    assign accept_s = ready_q && BYTE_VALID;
    assign hdr_n_s  = {BYTE_IN, count_q[7:0]};

    byte_packer u_packer (
        .clk       (CLK),
        .rst_n     (RST),
        .clr       (pk_clr_s),
        .byte_en   (accept_s && (state_q == ST_DATA)),
        .byte_in   (BYTE_IN),
        .word_full (pk_full_s),
        .word      (pk_word_s)
    );

    // Next-state and registered-output logic; outputs are derived from state_d
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        waddr_d  = waddr_q;
        datain_d = datain_q;
        err_d    = err_q;
        pk_clr_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (LOAD_START) begin
                    state_d  = ST_HDR_LO;
                    err_d    = 1'b0;
                    idx_d    = 16'd0;
                    count_d  = 16'd0;
                    pk_clr_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d    = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR_LO: begin
                if (accept_s) begin
                    count_d[7:0] = BYTE_IN;
                    state_d      = ST_HDR_HI;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_HI: begin
                if (accept_s) begin
                    count_d = hdr_n_s;
                    if ((hdr_n_s == 16'd0) || ({1'b0, hdr_n_s} > MAX_W)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept_s) begin
                    chk_d = chk_q ^ BYTE_IN;
                end else begin
                    chk_d = chk_q;
                end
`endif
                if (pk_full_s) begin
                    state_d  = ST_WRITE;
                    waddr_d  = word_addr(BASE_ADDR, idx_q);
                    datain_d = pk_word_s;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
                    state_d = ST_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    if (BYTE_IN == chk_q) begin
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
`endif
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_d    = (state_d == ST_WRITE);
        done_d  = (state_d == ST_FIN);
        hold_d  = (state_d != ST_IDLE);
`ifdef LOADER_CHECKSUM_EN
        ready_d = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                  (state_d == ST_DATA)   || (state_d == ST_CHK);
`else
        ready_d = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                  (state_d == ST_DATA);
`endif
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            count_q  <= 16'd0;
            idx_q    <= 16'd0;
            waddr_q  <= BASE_ADDR;
            datain_q <= 32'd0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            waddr_q  <= waddr_d;
            datain_q <= datain_d;
            wr_q     <= wr_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign BYTE_READY = ready_q;
    assign MEM_WADDR  = waddr_q;
    assign MEM_DATAIN = datain_q;
    assign MEM_WR     = wr_q;
    assign CPU_HOLD   = hold_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (default and LOADER_CHECKSUM_EN builds).
module tb_instr_mem_loader;

    logic        CLK;
    logic        RST;
    logic        LOAD_START;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        BYTE_READY;
    logic [63:0] MEM_WADDR;
    logic [31:0] MEM_DATAIN;
    logic        MEM_WR;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    int          hold_cycles = 0;
    int          done_count  = 0;
    int          both_count  = 0;
    logic [63:0] wa[$];
    logic [31:0] wd[$];

    instr_mem_loader #(.BASE_ADDR(64'd0), .MAX_WORDS(1024)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOAD_START (LOAD_START),
        .BYTE_IN    (BYTE_IN),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .MEM_WADDR  (MEM_WADDR),
        .MEM_DATAIN (MEM_DATAIN),
        .MEM_WR     (MEM_WR),
        .CPU_HOLD   (CPU_HOLD),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Passive monitor: write log, DONE pulses, hold cycles, ERR/DONE overlap
    always @(negedge CLK) begin
        if (MEM_WR) begin
            wa.push_back(MEM_WADDR);
            wd.push_back(MEM_DATAIN);
        end
        if (CPU_HOLD) hold_cycles <= hold_cycles + 1;
        if (DONE) done_count <= done_count + 1;
        if (DONE && ERR) both_count <= both_count + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns at #1 after the edge on which the byte was accepted
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        BYTE_IN    = b;
        BYTE_VALID = 1'b1;
        while (!BYTE_READY && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) chk("byte_ready_timeout", 64'(k), 64'd0);
        tick();
        BYTE_VALID = 1'b0;
    endtask

    task automatic start_load();
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
    endtask

    // From the WRITE cycle of the last word, advance to the FIN cycle
    task automatic finish_load(input logic [7:0] chk_byte);
`ifdef LOADER_CHECKSUM_EN
        send_byte(chk_byte);
`else
        if (chk_byte == 8'h00) tick(); else tick();
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(BYTE_READY), 64'd0);
        chk({tag, "_wr"},    64'(MEM_WR),     64'd0);
        chk({tag, "_waddr"}, MEM_WADDR,       64'd0);
        chk({tag, "_data"},  64'(MEM_DATAIN), 64'd0);
        chk({tag, "_hold"},  64'(CPU_HOLD),   64'd0);
        chk({tag, "_done"},  64'(DONE),       64'd0);
        chk({tag, "_err"},   64'(ERR),        64'd0);
    endtask

    initial begin
        int h0;
        int d0;
        int w0;
        RST        = 1'b0;
        LOAD_START = 1'b0;
        BYTE_IN    = 8'h00;
        BYTE_VALID = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        RST = 1'b1;
        tick();

        // N=2 back-to-back load
        h0 = hold_cycles; d0 = done_count; w0 = wa.size();
        start_load();
        chk("l1_hold_start", 64'(CPU_HOLD), 64'd1);
        chk("l1_ready_hdr", 64'(BYTE_READY), 64'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("l1_w0_wr",   64'(MEM_WR),     64'd1);
        chk("l1_w0_ready", 64'(BYTE_READY), 64'd0);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        chk("l1_w1_wr",    64'(MEM_WR),     64'd1);
        chk("l1_w1_addr",  MEM_WADDR,       64'd4);
        chk("l1_w1_data",  64'(MEM_DATAIN), 64'h0010_0093);
        finish_load(8'h90);
        chk("l1_fin_done", 64'(DONE),     64'd1);
        chk("l1_fin_hold", 64'(CPU_HOLD), 64'd1);
        chk("l1_fin_wr",   64'(MEM_WR),   64'd0);
        tick();
        chk("l1_idle_done", 64'(DONE),     64'd0);
        chk("l1_idle_hold", 64'(CPU_HOLD), 64'd0);
        chk("l1_addr_held", MEM_WADDR,     64'd4);
        chk("l1_data_held", 64'(MEM_DATAIN), 64'h0010_0093);
        chk("l1_nwrites",   64'(wa.size() - w0), 64'd2);
        chk("l1_log0_addr", wa[w0],     64'd0);
        chk("l1_log0_data", 64'(wd[w0]), 64'h0000_0013);
        chk("l1_log1_addr", wa[w0+1],   64'd4);
        chk("l1_log1_data", 64'(wd[w0+1]), 64'h0010_0093);
        chk("l1_done_cnt",  64'(done_count - d0), 64'd1);
`ifdef LOADER_CHECKSUM_EN
        chk("l1_hold_cycles", 64'(hold_cycles - h0), 64'd14);
`else
        chk("l1_hold_cycles", 64'(hold_cycles - h0), 64'd13);
`endif

        // Header N=0 then N=MAX_WORDS+1
        h0 = hold_cycles; w0 = wa.size();
        start_load();
        send_byte(8'h00); send_byte(8'h00);
        chk("n0_err",   64'(ERR),        64'd1);
        chk("n0_hold",  64'(CPU_HOLD),   64'd0);
        chk("n0_ready", 64'(BYTE_READY), 64'd0);
        chk("n0_done",  64'(DONE),       64'd0);
        chk("n0_hold_cycles", 64'(hold_cycles - h0), 64'd2);
        tick();
        chk("n0_err_sticky", 64'(ERR), 64'd1);
        start_load();
        chk("nmax_err_clr", 64'(ERR), 64'd0);
        send_byte(8'h01); send_byte(8'h04);
        chk("nmax_err",  64'(ERR),      64'd1);
        chk("nmax_hold", 64'(CPU_HOLD), 64'd0);
        chk("err_nwrites", 64'(wa.size() - w0), 64'd0);

        // N=1 with BYTE_VALID toggling
        d0 = done_count; w0 = wa.size();
        start_load();
        chk("tg_err_clr", 64'(ERR), 64'd0);
        send_byte(8'h01); tick(); send_byte(8'h00); tick();
        send_byte(8'h11); tick();
        chk("tg_ready_data", 64'(BYTE_READY), 64'd1);
        send_byte(8'h22); tick(); send_byte(8'h33); tick();
        send_byte(8'h44);
        chk("tg_wr",    64'(MEM_WR),     64'd1);
        chk("tg_ready_write", 64'(BYTE_READY), 64'd0);
        chk("tg_addr",  MEM_WADDR,       64'd0);
        chk("tg_data",  64'(MEM_DATAIN), 64'h4433_2211);
        finish_load(8'h44);
        chk("tg_done", 64'(DONE), 64'd1);
        tick();
        chk("tg_nwrites", 64'(wa.size() - w0), 64'd1);
        chk("tg_done_cnt", 64'(done_count - d0), 64'd1);

        // Reset after two payload bytes, then a fresh load
        start_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        RST = 1'b0;
        tick();
        check_reset_outputs("midrst");
        RST = 1'b1;
        tick();
        w0 = wa.size();
        start_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("rl_addr", MEM_WADDR,       64'd0);
        chk("rl_data", 64'(MEM_DATAIN), 64'h0403_0201);
        finish_load(8'h04);
        chk("rl_done", 64'(DONE), 64'd1);
        tick();
        chk("rl_nwrites", 64'(wa.size() - w0), 64'd1);

        // LOAD_START pulsed during DATA is ignored
        w0 = wa.size(); d0 = done_count;
        start_load();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66);
        LOAD_START = 1'b1;
        send_byte(8'h77);
        LOAD_START = 1'b0;
        chk("ls_hold", 64'(CPU_HOLD), 64'd1);
        send_byte(8'h88);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        finish_load(8'hEE);
        chk("ls_done", 64'(DONE), 64'd1);
        tick();
        chk("ls_nwrites",   64'(wa.size() - w0), 64'd2);
        chk("ls_log0_addr", wa[w0],       64'd0);
        chk("ls_log0_data", 64'(wd[w0]),  64'h8877_6655);
        chk("ls_log1_addr", wa[w0+1],     64'd4);
        chk("ls_log1_data", 64'(wd[w0+1]), 64'hEFBE_ADDE);
        chk("ls_done_cnt",  64'(done_count - d0), 64'd1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        d0 = done_count; w0 = wa.size();
        start_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13);
        chk("ck_ok_done", 64'(DONE), 64'd1);
        chk("ck_ok_err",  64'(ERR),  64'd0);
        tick();
        start_load();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h12);
        chk("ck_bad_err",  64'(ERR),      64'd1);
        chk("ck_bad_done", 64'(DONE),     64'd0);
        chk("ck_bad_hold", 64'(CPU_HOLD), 64'd0);
        tick();
        chk("ck_done_cnt", 64'(done_count - d0), 64'd1);
        chk("ck_nwrites",  64'(wa.size() - w0), 64'd2);
        chk("ck_bad_addr", wa[w0+1], 64'd0);
        chk("ck_bad_data", 64'(wd[w0+1]), 64'h0000_0013);
`endif

        tick();
        chk("err_done_overlap", 64'(both_count), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
